// File: rtl/fifomem_sync_if.sv
// FIFO handshake/data bundle; master drives write/read requests, slave is the FIFO.
// Latency: none, wires only.
// Backpressure: wfull/rempty tell the master when winc/rinc would be refused.
interface fifomem_sync_if #(
    parameter int WORDSIZE = 8,
    parameter int ADDRSIZE = 3
);
    logic                winc;
    logic [WORDSIZE-1:0] wdata;
    logic                rinc;
    logic                err_clr;
    logic [WORDSIZE-1:0] rdata;
    logic                wfull;
    logic                rempty;
    logic [ADDRSIZE:0]   count;
    logic                almost_full;
    logic                almost_empty;
    logic                overflow;
    logic                underflow;

    modport master (
        output winc, wdata, rinc, err_clr,
        input  rdata, wfull, rempty, count, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, err_clr,
        output rdata, wfull, rempty, count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifomem_sync.sv
// Single-clock FIFO of 2**ADDRSIZE words; define FIFOMEM_FWFT_EN for first-word fall-through.
// Latency: rdata 1 cycle after an accepted rinc (standard) or head always presented (FWFT).
// Backpressure: writes dropped while wfull (sets overflow), reads ignored while rempty (sets underflow).
module fifomem_sync #(
    parameter int WORDSIZE = 8,
    parameter int ADDRSIZE = 3,
    parameter int AF_LEVEL = 2**ADDRSIZE - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic            wclk,
    input  logic            wrst_n,
    fifomem_sync_if.slave   fif
);
    localparam int                DEPTH   = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AF_C    = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_C    = (ADDRSIZE+1)'(AE_LEVEL);
    localparam logic [ADDRSIZE:0] ONE_C   = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [WORDSIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE:0]   wptr, rptr, wptr_nxt, rptr_nxt;
    logic [ADDRSIZE:0]   count_q, count_nxt;
    logic [ADDRSIZE-1:0] waddr, raddr;
    logic                wr_acc, rd_acc;
    logic                wfull_q, rempty_q, af_q, ae_q;
    logic                ovf_q, udf_q;
    logic [WORDSIZE-1:0] rdata_q;

    assign waddr  = wptr[ADDRSIZE-1:0];
    assign raddr  = rptr[ADDRSIZE-1:0];
    assign wr_acc = fif.winc & ~wfull_q;
    assign rd_acc = fif.rinc & ~rempty_q;

    assign wptr_nxt = wptr + {{ADDRSIZE{1'b0}}, wr_acc};
    assign rptr_nxt = rptr + {{ADDRSIZE{1'b0}}, rd_acc};

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - ONE_C;
        end
    end

    // Flags are registered from the next-state count so they always agree with count.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            count_q  <= count_nxt;
            wfull_q  <= (count_nxt == DEPTH_C);
            rempty_q <= (count_nxt == '0);
            af_q     <= (count_nxt >= AF_C);
            ae_q     <= (count_nxt <= AE_C);
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (fif.winc & wfull_q)  | (ovf_q & ~fif.err_clr);
            udf_q <= (fif.rinc & rempty_q) | (udf_q & ~fif.err_clr);
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_acc) begin
            mem[waddr] <= fif.wdata;
        end
    end

`ifdef FIFOMEM_FWFT_EN
    logic [ADDRSIZE-1:0] raddr_nxt;
    logic [WORDSIZE-1:0] head_nxt;
    logic                head_load;

    // The memory keeps every word, head included; the output register mirrors the
    // head slot. The only time the new head is being written on the same edge is
    // when the FIFO ends up holding exactly that one word, so bypass wdata then.
    assign raddr_nxt = rptr_nxt[ADDRSIZE-1:0];
    assign head_nxt  = (wr_acc && (raddr_nxt == waddr)) ? fif.wdata : mem[raddr_nxt];
    assign head_load = (count_nxt != '0) && (rd_acc || rempty_q);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rdata_q <= '0;
        end else if (head_load) begin
            rdata_q <= head_nxt;
        end
    end
`else
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem[raddr];
        end
    end
`endif

    assign fif.rdata        = rdata_q;
    assign fif.wfull        = wfull_q;
    assign fif.rempty       = rempty_q;
    assign fif.count        = count_q;
    assign fif.almost_full  = af_q;
    assign fif.almost_empty = ae_q;
    assign fif.overflow     = ovf_q;
    assign fif.underflow    = udf_q;

endmodule

// File: tb/tb_fifomem_sync.sv
// Directed bench for fifomem_sync (default 8-bit x 8-deep); FIFOMEM_FWFT_EN selects the FWFT sequence.
module tb_fifomem_sync;
    logic wclk;
    logic wrst_n;
    int   vectors;
    int   miscompares;

    fifomem_sync_if #(.WORDSIZE(8), .ADDRSIZE(3)) bus ();

    fifomem_sync #(.WORDSIZE(8), .ADDRSIZE(3), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .fif    (bus)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdata"},   32'(bus.rdata), 32'h0);
        chk({tag, ".count"},   32'(bus.count), 32'h0);
        chk({tag, ".wfull"},   32'(bus.wfull), 32'h0);
        chk({tag, ".rempty"},  32'(bus.rempty), 32'h1);
        chk({tag, ".afull"},   32'(bus.almost_full), 32'h0);
        chk({tag, ".aempty"},  32'(bus.almost_empty), 32'h1);
        chk({tag, ".ovf"},     32'(bus.overflow), 32'h0);
        chk({tag, ".udf"},     32'(bus.underflow), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.winc    = 1'b0;
        bus.wdata   = '0;
        bus.rinc    = 1'b0;
        bus.err_clr = 1'b0;
        wrst_n      = 1'b1;
        #1 wrst_n   = 1'b0;
        #1;
        chk_reset("reset");
        tick();
        tick();
        wrst_n = 1'b1;

        // Fill with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            bus.winc  = 1'b1;
            bus.wdata = 8'(8'h11 + i);
            tick();
            chk($sformatf("fill%0d.count", i),  32'(bus.count), 32'(i + 1));
            chk($sformatf("fill%0d.afull", i),  32'(bus.almost_full), (i + 1 >= 7) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d.aempty", i), 32'(bus.almost_empty), (i == 0) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d.wfull", i),  32'(bus.wfull), (i == 7) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d.rempty", i), 32'(bus.rempty), 32'h0);
        end

        // Write while full is dropped
        bus.wdata = 8'hAA;
        tick();
        bus.winc = 1'b0;
        chk("ovf.flag",  32'(bus.overflow), 32'h1);
        chk("ovf.count", 32'(bus.count), 32'h8);
        chk("ovf.wfull", 32'(bus.wfull), 32'h1);
        chk("ovf.udf",   32'(bus.underflow), 32'h0);
        tick();
        chk("ovf.sticky", 32'(bus.overflow), 32'h1);

`ifdef FIFOMEM_FWFT_EN
        chk("fwft.head0", 32'(bus.rdata), 32'h11);
        for (int i = 0; i < 8; i++) begin
            bus.rinc = 1'b1;
            tick();
            chk($sformatf("fpop%0d.count", i), 32'(bus.count), 32'(7 - i));
            if (i < 7) chk($sformatf("fpop%0d.rdata", i), 32'(bus.rdata), 32'(8'h12 + i));
        end
        bus.rinc = 1'b0;
        chk("fdrain.rempty", 32'(bus.rempty), 32'h1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("fclr.ovf", 32'(bus.overflow), 32'h0);

        bus.winc  = 1'b1;
        bus.wdata = 8'h3C;
        tick();
        bus.winc = 1'b0;
        chk("f3c.rempty", 32'(bus.rempty), 32'h0);
        chk("f3c.rdata",  32'(bus.rdata), 32'h3C);
        chk("f3c.count",  32'(bus.count), 32'h1);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("f3c.pop.rempty", 32'(bus.rempty), 32'h1);
        chk("f3c.pop.count",  32'(bus.count), 32'h0);

        bus.winc = 1'b1;
        bus.wdata = 8'h41;
        tick();
        bus.wdata = 8'h42;
        tick();
        bus.winc = 1'b0;
        chk("f41.rdata", 32'(bus.rdata), 32'h41);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("f42.rdata", 32'(bus.rdata), 32'h42);
        chk("f42.count", 32'(bus.count), 32'h1);
`else
        chk("std.rdata.idle", 32'(bus.rdata), 32'h0);
        // Drain: data one cycle after each rinc, 0xAA never appears
        for (int i = 0; i < 8; i++) begin
            bus.rinc = 1'b1;
            tick();
            chk($sformatf("pop%0d.rdata", i), 32'(bus.rdata), 32'(8'h11 + i));
            chk($sformatf("pop%0d.count", i), 32'(bus.count), 32'(7 - i));
        end
        bus.rinc = 1'b0;
        chk("drain.rempty", 32'(bus.rempty), 32'h1);
        chk("drain.aempty", 32'(bus.almost_empty), 32'h1);
        chk("drain.udf",    32'(bus.underflow), 32'h0);

        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr.ovf", 32'(bus.overflow), 32'h0);

        // Read and write together on an empty FIFO: read refused, write taken
        bus.rinc  = 1'b1;
        bus.winc  = 1'b1;
        bus.wdata = 8'h5C;
        tick();
        bus.winc = 1'b0;
        chk("udf.flag",  32'(bus.underflow), 32'h1);
        chk("udf.count", 32'(bus.count), 32'h1);
        chk("udf.rdata", 32'(bus.rdata), 32'h18);
        tick();
        bus.rinc = 1'b0;
        chk("rd5c.rdata", 32'(bus.rdata), 32'h5C);
        chk("rd5c.count", 32'(bus.count), 32'h0);

        bus.err_clr = 1'b1;
        bus.rinc    = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("clrwin.udf", 32'(bus.underflow), 32'h1);
        tick();
        bus.err_clr = 1'b0;
        chk("clr.udf", 32'(bus.underflow), 32'h0);
        chk("clr.ovf2", 32'(bus.overflow), 32'h0);

        // Pointer wrap with occupancy held at 3
        bus.winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 8'(8'h20 + i);
            tick();
        end
        bus.rinc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.wdata = 8'(8'h23 + i);
            tick();
            chk($sformatf("wrap%0d.rdata", i), 32'(bus.rdata), 32'(8'h20 + i));
            chk($sformatf("wrap%0d.flags", i),
                32'({bus.count, bus.wfull, bus.rempty, bus.almost_full, bus.almost_empty}),
                32'({4'd3, 4'b0000}));
        end
        bus.rinc = 1'b0;

        // Bring occupancy to 5, then reset asynchronously mid-burst
        for (int i = 0; i < 2; i++) begin
            bus.wdata = 8'(8'h37 + i);
            tick();
        end
        chk("pre_rst.count", 32'(bus.count), 32'h5);
        bus.rinc = 1'b1;
        #2 wrst_n = 1'b0;
        #1;
        chk_reset("midrst");
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        wrst_n = 1'b1;

        bus.winc  = 1'b1;
        bus.wdata = 8'h77;
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("post_rst.rdata", 32'(bus.rdata), 32'h77);
        chk("post_rst.count", 32'(bus.count), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
